// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the RV32I pipeline hazard controller.
//   hz_state_e  : controller state (RUN, KILL = redirect parked, stale fetch
//                 still outstanding)
//   pipe_ctrl_t : the four pipeline-register enables and two flushes
//   HZ_REG_ADDR_W / HZ_XLEN : default register-index and PC widths
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;
  localparam int HZ_XLEN       = 32;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  // Free-running pipeline: everything advances, nothing flushed.
  localparam pipe_ctrl_t CTRL_RUN    = pipe_ctrl_t'(6'b1111_00);
  // Front end held, bubble injected into ID/EX, back end drains.
  localparam pipe_ctrl_t CTRL_BUBBLE = pipe_ctrl_t'(6'b0111_01);
  // Whole pipeline frozen.
  localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(6'b0000_00);

endpackage

// File: rtl/hazard_lu_detect.sv
// -----------------------------------------------------------------------------
// hazard_lu_detect
// Purely combinational load-use detector: flags an ID instruction that reads
// the destination of a load currently in EX. x0 is never a hazard.
// Ports:
//   id_valid_i, id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i : ID operands
//   ex_valid_i, ex_rd_i, ex_is_load_i                            : EX producer
//   lu_o                                                         : load-use hit
// -----------------------------------------------------------------------------
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_valid_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_is_load_i,
  output logic                  lu_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  assign lu_o = ex_valid_i && ex_is_load_i && (ex_rd_i != '0) &&
                id_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline control for the 5-stage RV32I core: drives the PC enable/redirect
// and the IF/ID, ID/EX, EX/MEM, MEM/WB enables and flushes. Handles load-use
// bubbles, I-/D-memory wait freezes and EX-resolved redirects; a redirect that
// arrives while a fetch is outstanding is parked until that fetch returns, and
// the returning stale word is marked for discard.
// Ports:
//   clk, rst (async, active-low)
//   id_*  : ID-stage operand info           ex_*  : EX-stage producer/redirect
//   imem_req/imem_resp, dmem_req/dmem_resp  : memory handshakes
//   pc_en, pc_redirect, redirect_pc         : PC control
//   if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush
//   fetch_discard                           : drop the returning fetch word
// Optional build macro HAZARD_PERF_EN adds four CNT_W saturating event
// counters (perf_lu, perf_dfrz, perf_ifrz, perf_redirect).
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W,
  parameter int XLEN       = HZ_XLEN
`ifdef HAZARD_PERF_EN
  ,parameter int CNT_W     = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  ex_redirect,
  input  logic [XLEN-1:0]       ex_target,
  input  logic                  imem_req,
  input  logic                  imem_resp,
  input  logic                  dmem_req,
  input  logic                  dmem_resp,
  output logic                  pc_en,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  fetch_discard
`ifdef HAZARD_PERF_EN
  ,output logic [CNT_W-1:0]     perf_lu
  ,output logic [CNT_W-1:0]     perf_dfrz
  ,output logic [CNT_W-1:0]     perf_ifrz
  ,output logic [CNT_W-1:0]     perf_redirect
`endif
);

  hz_state_e       state_q, state_d;
  logic [XLEN-1:0] park_pc_q, park_pc_d;
  pipe_ctrl_t      ctrl;
  logic            dfrz, ifrz, lu;

  assign dfrz = dmem_req && !dmem_resp;
  assign ifrz = imem_req && !imem_resp;

  hazard_lu_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu (
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs1_i (id_uses_rs1),
    .id_uses_rs2_i (id_uses_rs2),
    .ex_valid_i    (ex_valid),
    .ex_rd_i       (ex_rd),
    .ex_is_load_i  (ex_is_load),
    .lu_o          (lu)
  );

  // Priority-ordered control decode; outputs are combinational from state.
  always_comb begin
    state_d       = state_q;
    park_pc_d     = park_pc_q;
    ctrl          = CTRL_RUN;
    pc_en         = 1'b1;
    pc_redirect   = 1'b0;
    redirect_pc   = ex_target;
    fetch_discard = 1'b0;

    if (dfrz) begin
      // A redirect sitting in EX is frozen with it and acts once dfrz drops.
      ctrl  = CTRL_FREEZE;
      pc_en = 1'b0;
    end else if (state_q == KILL) begin
      ctrl        = CTRL_BUBBLE;
      pc_en       = 1'b0;
      redirect_pc = park_pc_q;
      if (imem_resp) begin
        fetch_discard    = 1'b1;
        pc_en            = 1'b1;
        pc_redirect      = 1'b1;
        ctrl.if_id_flush = 1'b1;
        state_d          = RUN;
      end
    end else if (ex_redirect && !ifrz) begin
      // Also covers redirect coinciding with imem_resp: the word is flushed.
      pc_redirect      = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (ex_redirect) begin
      park_pc_d        = ex_target;
      state_d          = KILL;
      pc_en            = 1'b0;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (lu || ifrz) begin
      ctrl  = CTRL_BUBBLE;
      pc_en = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      park_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      park_pc_q <= park_pc_d;
    end
  end

  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_mem_en   = ctrl.ex_mem_en;
  assign mem_wb_en   = ctrl.mem_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

`ifdef HAZARD_PERF_EN
  // Each counter tracks the cycles in which its case wins the priority decode.
  logic ev_lu, ev_dfrz, ev_ifrz, ev_redir;
  logic [CNT_W-1:0] perf_lu_q, perf_dfrz_q, perf_ifrz_q, perf_redirect_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign ev_dfrz  = dfrz;
  assign ev_lu    = !dfrz && (state_q == RUN) && !ex_redirect && lu;
  assign ev_ifrz  = !dfrz && (state_q == RUN) && !ex_redirect && !lu && ifrz;
  assign ev_redir = !dfrz && (((state_q == RUN) && ex_redirect && !ifrz) ||
                              ((state_q == KILL) && imem_resp));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_lu_q       <= '0;
      perf_dfrz_q     <= '0;
      perf_ifrz_q     <= '0;
      perf_redirect_q <= '0;
    end else begin
      if (ev_lu)    perf_lu_q       <= sat_inc(perf_lu_q);
      if (ev_dfrz)  perf_dfrz_q     <= sat_inc(perf_dfrz_q);
      if (ev_ifrz)  perf_ifrz_q     <= sat_inc(perf_ifrz_q);
      if (ev_redir) perf_redirect_q <= sat_inc(perf_redirect_q);
    end
  end

  assign perf_lu       = perf_lu_q;
  assign perf_dfrz     = perf_dfrz_q;
  assign perf_ifrz     = perf_ifrz_q;
  assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector bench for hazard_ctrl (default build, perf counters absent).
// Control outputs are packed into one 9-bit word:
//   {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//    if_id_flush, id_ex_flush, fetch_discard}
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [8:0] O_IDLE  = 9'b1_0_1111_00_0;
  localparam logic [8:0] O_BUBL  = 9'b0_0_0111_01_0;
  localparam logic [8:0] O_REDIR = 9'b1_1_1111_11_0;
  localparam logic [8:0] O_PARK  = 9'b0_0_1111_11_0;
  localparam logic [8:0] O_FRZ   = 9'b0_0_0000_00_0;
  localparam logic [8:0] O_KRESP = 9'b1_1_0111_11_1;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_valid, ex_is_load, ex_redirect;
  logic [31:0] ex_target;
  logic        imem_req, imem_resp, dmem_req, dmem_resp;
  logic        pc_en, pc_redirect;
  logic [31:0] redirect_pc;
  logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, fetch_discard;
  logic [8:0]  obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign obs = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_flush, id_ex_flush, fetch_discard};

  hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_is_load    (ex_is_load),
    .ex_redirect   (ex_redirect),
    .ex_target     (ex_target),
    .imem_req      (imem_req),
    .imem_resp     (imem_resp),
    .dmem_req      (dmem_req),
    .dmem_resp     (dmem_resp),
    .pc_en         (pc_en),
    .pc_redirect   (pc_redirect),
    .redirect_pc   (redirect_pc),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .fetch_discard (fetch_discard)
  );

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    imem_req = 1'b0; imem_resp = 1'b0; dmem_req = 1'b0; dmem_resp = 1'b0;
  endtask

  // Advance to just after the next active edge, ready to drive a new vector.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Set up lw x<rd> in EX and an ID instruction reading rs1/rs2.
  task automatic load_use(input logic [4:0] rd, input logic [4:0] r1,
                          input logic u1, input logic [4:0] r2, input logic u2);
    idle_inputs();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = rd;
    id_valid = 1'b1; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #2;
    check_val("reset_idle_ctrl", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();
    rst = 1'b1;

    // lw x5 in EX, add x6,x5,x2 in ID: one bubble, then the bubble reaches EX.
    load_use(5'd5, 5'd5, 1'b1, 5'd2, 1'b1);
    @(negedge clk); check_val("lu_rs1_stall", {23'd0, obs}, {23'd0, O_BUBL});
    next_cycle();
    ex_valid = 1'b0;
    @(negedge clk); check_val("lu_release", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();

    load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    @(negedge clk); check_val("lu_rs2_stall", {23'd0, obs}, {23'd0, O_BUBL});
    next_cycle();

    load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    @(negedge clk); check_val("lu_unused_src", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();

    load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk); check_val("lu_x0", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();

    load_use(5'd9, 5'd9, 1'b1, 5'd1, 1'b1);
    id_valid = 1'b0;
    @(negedge clk); check_val("lu_id_invalid", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();

    // Redirect with imem idle: applied the same cycle.
    idle_inputs();
    ex_redirect = 1'b1; ex_target = 32'h6000_0040;
    @(negedge clk);
    check_val("redir_ctrl", {23'd0, obs}, {23'd0, O_REDIR});
    check_val("redir_pc", redirect_pc, 32'h6000_0040);
    next_cycle();

    // Redirect wins over a simultaneous load-use.
    load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    ex_redirect = 1'b1; ex_target = 32'h0000_0a00;
    @(negedge clk);
    check_val("redir_over_lu", {23'd0, obs}, {23'd0, O_REDIR});
    check_val("redir_over_lu_pc", redirect_pc, 32'h0000_0a00);
    next_cycle();

    // Redirect coinciding with imem_resp: not parked, no discard.
    idle_inputs();
    imem_req = 1'b1; imem_resp = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0b00;
    @(negedge clk); check_val("redir_with_resp", {23'd0, obs}, {23'd0, O_REDIR});
    next_cycle();

    // Plain I-fetch wait bubbles the front end.
    idle_inputs();
    imem_req = 1'b1;
    @(negedge clk); check_val("ifrz_bubble", {23'd0, obs}, {23'd0, O_BUBL});
    next_cycle();

    // Redirect while fetch outstanding: park, wait, freeze inside KILL, resolve.
    idle_inputs();
    imem_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0100;
    @(negedge clk); check_val("park", {23'd0, obs}, {23'd0, O_PARK});
    next_cycle();
    ex_redirect = 1'b0; ex_target = 32'h0000_0dd0;
    @(negedge clk); check_val("kill_wait1", {23'd0, obs}, {23'd0, O_BUBL});
    next_cycle();
    dmem_req = 1'b1;
    @(negedge clk); check_val("kill_dfrz", {23'd0, obs}, {23'd0, O_FRZ});
    next_cycle();
    dmem_req = 1'b0;
    @(negedge clk); check_val("kill_wait2", {23'd0, obs}, {23'd0, O_BUBL});
    next_cycle();
    imem_resp = 1'b1;
    @(negedge clk);
    check_val("kill_resp", {23'd0, obs}, {23'd0, O_KRESP});
    check_val("kill_resp_pc", redirect_pc, 32'h0000_0100);
    next_cycle();
    idle_inputs();
    @(negedge clk); check_val("kill_back_run", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();

    // D-memory wait freezes everything, redirect held until it clears.
    idle_inputs();
    dmem_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check_val($sformatf("dfrz_%0d", i), {23'd0, obs}, {23'd0, O_FRZ});
      next_cycle();
    end
    dmem_resp = 1'b1;
    @(negedge clk);
    check_val("dfrz_redir", {23'd0, obs}, {23'd0, O_REDIR});
    check_val("dfrz_redir_pc", redirect_pc, 32'h0000_0200);
    next_cycle();

    // Reset asserted mid-KILL: immediate return to RUN, parked PC cleared.
    idle_inputs();
    imem_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h0000_0300;
    @(negedge clk); check_val("park2", {23'd0, obs}, {23'd0, O_PARK});
    next_cycle();
    ex_redirect = 1'b0;
    @(negedge clk); check_val("kill2_wait", {23'd0, obs}, {23'd0, O_BUBL});
    #1;
    rst = 1'b0;
    imem_req = 1'b0;
    #1;
    check_val("rst_async_ctrl", {23'd0, obs}, {23'd0, O_IDLE});
    check_val("rst_park_pc", dut.park_pc_q, 32'h0);
    next_cycle();
    rst = 1'b1;
    imem_req = 1'b1; imem_resp = 1'b1;
    @(negedge clk); check_val("post_rst_resp", {23'd0, obs}, {23'd0, O_IDLE});
    next_cycle();
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
